ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter RAM_ADDR_BITS, default 8, RAM address width.
REQ-002 Parameter RAM_WIDTH, default 8, RAM data width.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_sync  input  1  synchronous reset, active-high.
REQ-005 req0_valid/req1_valid  input  1 each  access request (0 = UART command path, 1 = local requester).
REQ-006 req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-007 req0_we/req1_we  input  1 each  1 = write, 0 = read.
REQ-008 req0_addr/req1_addr  input  RAM_ADDR_BITS each  access address.
REQ-009 req0_wdata/req1_wdata  input  RAM_WIDTH each  write data.
REQ-010 rsp0_valid/rsp1_valid  output  1 each  one-cycle completion pulse (read data or write ack).
REQ-011 rsp0_rdata/rsp1_rdata  output  RAM_WIDTH each  read data; qualified by rspN_valid.
REQ-012 ram_en, ram_we  output  1 each  single-port block RAM enable / write enable.
REQ-013 ram_addr  output  RAM_ADDR_BITS; ram_wdata  output  RAM_WIDTH  RAM port.
REQ-014 ram_rdata  input  RAM_WIDTH  RAM read data, valid the cycle after ram_en with ram_we=0.
REQ-015 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 In IDLE exactly one reqN_ready asserted, combinationally, for the arbitration winner among asserted valids; none if no valid; all ready low outside IDLE.
REQ-018 Accept = reqN_valid & reqN_ready; on accept register winner index, we, addr, wdata.
REQ-019 ACCESS: ram_en=1, ram_we/addr/wdata from registered request; ram_en=0 in all other states.
REQ-020 RESP: rspN_valid=1 for registered winner only, one cycle; rspN_rdata = ram_rdata for reads, 0 for writes.
REQ-021 Latency accept cycle T -> ram_en at T+1 -> rsp_valid at T+2; max throughput one access per 3 cycles.
REQ-022 Arbitration round-robin: single pointer; after grant to N, pointer favours the other requester; with one valid, it wins regardless of pointer.
REQ-023 Simultaneous valids: pointer holder wins; loser keeps valid, granted in next IDLE (no starvation; worst-case wait 3 cycles).
REQ-024 Requesters hold valid and fields stable until ready; deasserting valid before ready is legal and drops the request without side effect.
REQ-025 rspN_rdata holds last value between pulses; non-winner rsp_rdata unchanged.

Reset
REQ-026 rst_sync sampled high: next state IDLE, pointer favours requester 0, registered request cleared to 0.
REQ-027 Reset values: req*_ready per REQ-017 from IDLE, rsp*_valid=0, rsp*_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0.
REQ-028 Reset mid-operation (ACCESS or RESP): transaction abandoned, no rsp_valid pulse issued, ram_en low from the next cycle.

Configuration
REQ-029 Macro RAM_ARB_FIXED_PRIO_EN: defined -> requester 0 wins every contended IDLE cycle, pointer logic absent; undefined -> round-robin per REQ-022/REQ-023.
REQ-030 Interface, latency and reset behaviour identical in both builds.

Verification
REQ-031 Reset, req0 write addr 0x10 data 0xA5 -> ram_en/ram_we at T+1 with addr 0x10, wdata 0xA5; rsp0_valid at T+2, rsp0_rdata=0x00.
REQ-032 req1 read addr 0x10 after REQ-031 write, RAM model returns 0xA5 -> rsp1_valid at T+2, rsp1_rdata=0xA5, rsp0_valid stays 0.
REQ-033 Both valid continuously, reads addr 0x01 (req0) and 0x02 (req1), round-robin build -> grants 0,1,0,1 every 3 cycles; fixed-prio build -> only req0 granted.
REQ-034 Assert rst_sync during ACCESS of req0 read -> no rsp0_valid, busy=0 and ram_en=0 next cycle, pointer back to requester 0.
REQ-035 req1 valid, dropped before ready while FSM busy -> no RAM access, no rsp1_valid.
REQ-036 Back-to-back req0 writes to 0xFF with data 0x00 then 0xFF -> two ram_en pulses 3 cycles apart, addr 0xFF, final RAM content 0xFF.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port block RAM: IDLE -> ACCESS -> RESP per transaction.
// Optional macro RAM_ARB_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin pointer).
module ram_port_arbiter #(
  parameter int RAM_ADDR_BITS = 8,
  parameter int RAM_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_sync,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [RAM_ADDR_BITS-1:0] req0_addr,
  input  logic [RAM_WIDTH-1:0]     req0_wdata,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [RAM_ADDR_BITS-1:0] req1_addr,
  input  logic [RAM_WIDTH-1:0]     req1_wdata,
  output logic                     rsp0_valid,
  output logic [RAM_WIDTH-1:0]     rsp0_rdata,
  output logic                     rsp1_valid,
  output logic [RAM_WIDTH-1:0]     rsp1_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_wdata,
  input  logic [RAM_WIDTH-1:0]     ram_rdata,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     win_q, win_d;
  logic                     we_q, we_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     wdata_q, wdata_d;
  logic [RAM_WIDTH-1:0]     rsp0_rdata_q, rsp0_rdata_d;
  logic [RAM_WIDTH-1:0]     rsp1_rdata_q, rsp1_rdata_d;
  logic [RAM_WIDTH-1:0]     resp_data;
  logic                     grant0, grant1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`else
  // ptr_q set means requester 1 holds priority on the next contended cycle
  logic ptr_q, ptr_d;

  always_comb begin
    grant1 = req1_valid & (ptr_q | ~req0_valid);
    grant0 = req0_valid & ~grant1;
  end
`endif

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    resp_data    = we_q ? '0 : ram_rdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
    ptr_d        = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) begin
          state_d = ACCESS;
          win_d   = grant1;
          we_d    = grant1 ? req1_we    : req0_we;
          addr_d  = grant1 ? req1_addr  : req0_addr;
          wdata_d = grant1 ? req1_wdata : req0_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
          ptr_d   = grant0;
`endif
        end
      end
      ACCESS: begin
        ram_en  = 1'b1;
        ram_we  = we_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        // A reset landing on the response cycle abandons the transaction outright
        if (win_q) begin
          rsp1_valid   = ~rst_sync;
          rsp1_rdata_d = resp_data;
        end else begin
          rsp0_valid   = ~rst_sync;
          rsp0_rdata_d = resp_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q      <= IDLE;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // Response data is visible during the RESP cycle itself and then held
  assign rsp0_rdata = rsp0_rdata_d;
  assign rsp1_rdata = rsp1_rdata_d;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural single-port RAM model.
// Honours RAM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_sync;
  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       busy;
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  ram_port_arbiter #(.RAM_ADDR_BITS(8), .RAM_WIDTH(8)) dut (
    .clk        (clk),
    .rst_sync   (rst_sync),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: reset fills mem[i] = i; one-cycle read latency
  always @(posedge clk) begin
    if (rst_sync) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                               input logic v1, input logic we1, input logic [7:0] a1, input logic [7:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
  endtask

  initial begin
    int exp_win;
    rst_sync = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_rsp0_rdata", rsp0_rdata, 0);
    rst_sync = 1'b0;
    #1;
    checkOutput("idle_no_ready0", req0_ready, 0);

    $display("[TB] req0 write 0x10 <- 0xA5");
    applyStimulus(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    checkOutput("w_ready0", req0_ready, 1);
    checkOutput("w_ready1", req1_ready, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("w_ram_en", ram_en, 1);
    checkOutput("w_ram_we", ram_we, 1);
    checkOutput("w_ram_addr", ram_addr, 8'h10);
    checkOutput("w_ram_wdata", ram_wdata, 8'hA5);
    checkOutput("w_busy", busy, 1);
    checkOutput("w_ready_busy", req0_ready, 0);
    tick();
    checkOutput("w_rsp0_valid", rsp0_valid, 1);
    checkOutput("w_rsp0_rdata", rsp0_rdata, 8'h00);
    checkOutput("w_rsp1_valid", rsp1_valid, 0);
    checkOutput("w_resp_ram_en", ram_en, 0);
    tick();
    checkOutput("w_done_busy", busy, 0);
    checkOutput("w_done_rsp0", rsp0_valid, 0);

    $display("[TB] req1 read 0x10");
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    checkOutput("r_ready1", req1_ready, 1);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("r_ram_en", ram_en, 1);
    checkOutput("r_ram_we", ram_we, 0);
    checkOutput("r_ram_addr", ram_addr, 8'h10);
    tick();
    checkOutput("r_rsp1_valid", rsp1_valid, 1);
    checkOutput("r_rsp1_rdata", rsp1_rdata, 8'hA5);
    checkOutput("r_rsp0_valid", rsp0_valid, 0);
    checkOutput("r_rsp0_hold", rsp0_rdata, 8'h00);
    tick();
    checkOutput("r_rsp1_valid_off", rsp1_valid, 0);
    checkOutput("r_rsp1_hold", rsp1_rdata, 8'hA5);

    $display("[TB] contention: req0 reads 0x01, req1 reads 0x02");
    applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    for (int g = 0; g < 4; g++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_win = 0;
`else
      exp_win = g % 2;
`endif
      checkOutput("c_ready0", req0_ready, 32'(exp_win == 0));
      checkOutput("c_ready1", req1_ready, 32'(exp_win == 1));
      tick();
      checkOutput("c_ram_addr", ram_addr, (exp_win == 1) ? 8'h02 : 8'h01);
      tick();
      checkOutput("c_rsp0_valid", rsp0_valid, 32'(exp_win == 0));
      checkOutput("c_rsp1_valid", rsp1_valid, 32'(exp_win == 1));
      checkOutput("c_rdata", (exp_win == 1) ? rsp1_rdata : rsp0_rdata, (exp_win == 1) ? 8'h02 : 8'h01);
      tick();
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

    $display("[TB] reset during ACCESS of req0 read");
    applyStimulus(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("x_ram_en_access", ram_en, 1);
    rst_sync = 1'b1;
    tick();
    checkOutput("x_busy", busy, 0);
    checkOutput("x_ram_en", ram_en, 0);
    checkOutput("x_rsp0_valid", rsp0_valid, 0);
    checkOutput("x_rsp1_rdata_clr", rsp1_rdata, 0);
    rst_sync = 1'b0;
    applyStimulus(1, 0, 8'h04, 8'h00, 1, 0, 8'h05, 8'h00);
    checkOutput("x_ptr_ready0", req0_ready, 1);
    checkOutput("x_ptr_ready1", req1_ready, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("x_drop_busy", busy, 0);
    checkOutput("x_no_rsp0", rsp0_valid, 0);

    $display("[TB] req1 dropped while busy");
    applyStimulus(1, 1, 8'h20, 8'h5A, 0, 0, 8'h00, 8'h00);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
    checkOutput("d_ready1_access", req1_ready, 0);
    tick();
    checkOutput("d_ready1_resp", req1_ready, 0);
    checkOutput("d_rsp0_valid", rsp0_valid, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("d_idle_busy", busy, 0);
    checkOutput("d_ready1_idle", req1_ready, 0);
    tick();
    checkOutput("d_ram_en", ram_en, 0);
    checkOutput("d_rsp1_valid", rsp1_valid, 0);

    $display("[TB] back-to-back req0 writes to 0xFF");
    applyStimulus(1, 1, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("b_ready0_first", req0_ready, 1);
    tick();
    applyStimulus(1, 1, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00);
    checkOutput("b_ram_en_first", ram_en, 1);
    checkOutput("b_addr_first", ram_addr, 8'hFF);
    checkOutput("b_wdata_first", ram_wdata, 8'h00);
    tick();
    checkOutput("b_ram_en_gap", ram_en, 0);
    checkOutput("b_mem_first", mem[8'hFF], 8'h00);
    tick();
    checkOutput("b_ready0_second", req0_ready, 1);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("b_ram_en_second", ram_en, 1);
    checkOutput("b_addr_second", ram_addr, 8'hFF);
    checkOutput("b_wdata_second", ram_wdata, 8'hFF);
    tick();
    checkOutput("b_mem_final", mem[8'hFF], 8'hFF);
    tick();
    checkOutput("b_final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
